// File: rtl/sub32_pkg.sv
// Shared constants and types for the chunked 32-bit pipelined subtractor.
// Optional feature macro: SUB_OVF_EN (adds the signed-overflow output).
package sub32_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned NUM_STAGES  = 8;
    localparam int unsigned NUM_CHUNKS  = 7;
    localparam int unsigned CHUNK_W_MAX = 6;

    // Chunk k covers bits [CHUNK_LO[k] +: CHUNK_W[k]], LSB chunk first
    localparam int unsigned CHUNK_W  [NUM_CHUNKS] = '{6, 6, 4, 4, 4, 4, 4};
    localparam int unsigned CHUNK_LO [NUM_CHUNKS] = '{0, 6, 12, 16, 20, 24, 28};

    // Container wide enough for any chunk's data bits
    typedef logic [CHUNK_W_MAX-1:0] chunk_t;

endpackage

// File: rtl/rtl_sub32_pipe_if.sv
// Operation/result bundle for rtl_sub32_pipe.
// master: drives ce, valid_in, a, b, bin; slave: drives d, bout, valid_out (and ovf).
// Optional feature macro: SUB_OVF_EN (adds ovf).
interface rtl_sub32_pipe_if;
    import sub32_pkg::*;

    logic              ce;
    logic              valid_in;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              bin;
    logic [DATA_W-1:0] d;
    logic              bout;
    logic              valid_out;
`ifdef SUB_OVF_EN
    logic              ovf;
`endif

    modport master (
        output ce, valid_in, a, b, bin,
`ifdef SUB_OVF_EN
        input  ovf,
`endif
        input  d, bout, valid_out
    );

    modport slave (
        input  ce, valid_in, a, b, bin,
`ifdef SUB_OVF_EN
        output ovf,
`endif
        output d, bout, valid_out
    );

endinterface

// File: rtl/sub_chunk_reg.sv
// Registered W-bit subtract with borrow: {o_bout, o_diff} <= i_a - i_b - i_bin.
// Ports: clk, rst (sync, active-high), ce (advance), i_a/i_b (chunk operands),
//        i_bin (borrow in), o_diff (chunk difference), o_bout (borrow out).
module sub_chunk_reg #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic [W-1:0] o_diff,
    output logic         o_bout
);

    logic [W:0]   w_res;
    logic [W-1:0] r_diff;
    logic         r_bout;

    // One extra bit on top catches the borrow as the sign of the result
    assign w_res = {1'b0, i_a} - {1'b0, i_b} - (W+1)'(i_bin);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (ce) begin
            {r_bout, r_diff} <= w_res;
        end
    end

    assign o_diff = r_diff;
    assign o_bout = r_bout;

endmodule

// File: rtl/rtl_sub32_pipe.sv
// 32-bit subtractor d = a - b - bin, pipelined one chunk per stage with
// operand skew and result deskew; 8 ce-enabled edges of latency, 1 op/cycle.
// Ports: clk, rst (sync, active-high), bus (rtl_sub32_pipe_if.slave):
//        ce, valid_in, a, b, bin in; d, bout, valid_out (and ovf) out.
// Optional feature macro: SUB_OVF_EN (signed overflow output ovf).
module rtl_sub32_pipe
    import sub32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    rtl_sub32_pipe_if.slave  bus
);

    logic [DATA_W-1:0]     r_a0;
    logic [DATA_W-1:0]     r_b0;
    logic                  r_bin0;
    logic [NUM_STAGES-1:0] r_valid;
    logic                  r_valid_out;
    logic [DATA_W-1:0]     r_d;
    logic                  r_bout;

    // w_borrow[k]: borrow registered by chunk k; w_d_pre: deskewed difference
    logic                  w_borrow [NUM_CHUNKS];
    logic [DATA_W-1:0]     w_d_pre;

`ifdef SUB_OVF_EN
    logic                  w_sign_a;
    logic                  w_sign_b;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic                  r_ovf;
`endif

    // Stage 0 input capture and valid shift line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a0    <= '0;
            r_b0    <= '0;
            r_bin0  <= 1'b0;
            r_valid <= '0;
        end else if (bus.ce) begin
            r_a0    <= bus.a;
            r_b0    <= bus.b;
            r_bin0  <= bus.bin;
            r_valid <= {r_valid[NUM_STAGES-2:0], bus.valid_in};
        end
    end

    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
        localparam int unsigned W  = CHUNK_W[k];
        localparam int unsigned LO = CHUNK_LO[k];
        localparam int unsigned DQ = NUM_CHUNKS - 1 - k;

        logic [W-1:0] w_op_a;
        logic [W-1:0] w_op_b;
        logic         w_bin;
        logic [W-1:0] w_diff;

        if (k == 0) begin : g_first
            assign w_op_a = r_a0[LO +: W];
            assign w_op_b = r_b0[LO +: W];
            assign w_bin  = r_bin0;
        end else begin : g_skew
            // Delay this chunk's operands k stages to meet its incoming borrow
            logic [W-1:0] r_sa [k];
            logic [W-1:0] r_sb [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < k; i++) begin
                        r_sa[i] <= '0;
                        r_sb[i] <= '0;
                    end
                end else if (bus.ce) begin
                    r_sa[0] <= r_a0[LO +: W];
                    r_sb[0] <= r_b0[LO +: W];
                    for (int i = 1; i < k; i++) begin
                        r_sa[i] <= r_sa[i-1];
                        r_sb[i] <= r_sb[i-1];
                    end
                end
            end

            assign w_op_a = r_sa[k-1];
            assign w_op_b = r_sb[k-1];
            assign w_bin  = w_borrow[k-1];

`ifdef SUB_OVF_EN
            if (k == NUM_CHUNKS - 1) begin : g_sign
                assign w_sign_a = r_sa[k-1][W-1];
                assign w_sign_b = r_sb[k-1][W-1];
            end
`endif
        end

        sub_chunk_reg #(.W(W)) u_sub (
            .clk    (clk),
            .rst    (rst),
            .ce     (bus.ce),
            .i_a    (w_op_a),
            .i_b    (w_op_b),
            .i_bin  (w_bin),
            .o_diff (w_diff),
            .o_bout (w_borrow[k])
        );

        if (DQ == 0) begin : g_last
            assign w_d_pre[LO +: W] = w_diff;
        end else begin : g_deskew
            // Hold early chunks until the top chunk resolves; output reg adds the final stage
            logic [W-1:0] r_dq [DQ];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(DQ); i++) begin
                        r_dq[i] <= '0;
                    end
                end else if (bus.ce) begin
                    r_dq[0] <= w_diff;
                    for (int i = 1; i < int'(DQ); i++) begin
                        r_dq[i] <= r_dq[i-1];
                    end
                end
            end

            assign w_d_pre[LO +: W] = r_dq[DQ-1];
        end
    end

    // Output register: results only update on a valid op, otherwise held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_d         <= '0;
            r_bout      <= 1'b0;
        end else if (bus.ce) begin
            r_valid_out <= r_valid[NUM_STAGES-1];
            if (r_valid[NUM_STAGES-1]) begin
                r_d    <= w_d_pre;
                r_bout <= w_borrow[NUM_CHUNKS-1];
            end
        end
    end

`ifdef SUB_OVF_EN
    // Sign bits ride alongside the top chunk so ovf lines up with d
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (bus.ce) begin
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            if (r_valid[NUM_STAGES-1]) begin
                r_ovf <= (r_sign_a != r_sign_b) && (w_d_pre[DATA_W-1] != r_sign_a);
            end
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.d         = r_d;
    assign bus.bout      = r_bout;
    assign bus.valid_out = r_valid_out;

endmodule

// File: doc/rtl_sub32_pipe.md
RTL_SUB32_PIPE -- requirements
Module: rtl_sub32_pipe

Interface
REQ-001 SHALL have no parameters; chunk widths and depth are fixed package constants.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ce  input  1  pipeline advance enable; 0 freezes every pipeline register.
REQ-005 valid_in  input  1  a/b/bin qualify as an operation on this edge.
REQ-006 a  input  32  minuend.
REQ-007 b  input  32  subtrahend.
REQ-008 bin  input  1  borrow-in (subtracted from the result).
REQ-009 d  output  32  difference a - b - bin, mod 2^32.
REQ-010 bout  output  1  borrow-out; 1 when a < b + bin (unsigned).
REQ-011 valid_out  output  1  d/bout hold a completed operation.
REQ-012 ovf  output  1  signed overflow (present only with SUB_OVF_EN).

Function
REQ-013 SHALL split operands into 7 chunks, LSB first: [5:0],[11:6],[15:12],[19:16],[23:20],[27:24],[31:28].
REQ-014 SHALL register inputs in stage 0, then resolve one chunk per stage (stages 1..7), chunk k using the borrow registered by chunk k-1 (chunk 0 uses bin).
REQ-015 SHALL skew operands, so chunk k's operands are delayed k stages, and deskew results, so each completed chunk is delayed 7-k stages; all 32 bits of d emerge together.
REQ-016 SHALL have latency of exactly 8 ce-enabled edges from the sampling edge to d/bout/valid_out.
REQ-017 SHALL accept one operation per ce-enabled edge (throughput 1/cycle) with no bubbles required.
REQ-018 SHALL compute each chunk as {borrow, diff} = chunk_a - chunk_b - borrow_in, zero-extended one bit; borrow = MSB of that result.
REQ-019 SHALL shift valid through an 8-deep valid pipeline in lockstep with data; valid_in=0 injects a bubble with valid_out=0.
REQ-020 SHALL hold all data, borrow and valid registers, including outputs, when ce=0; valid_in is ignored while ce=0.
REQ-021 SHALL hold d/bout at their last values while valid_out=0 (not forced to 0), except after reset.
REQ-022 bin=1 with a=b SHALL yield d=32'hFFFFFFFF, bout=1 (full-width borrow ripple).

Reset
REQ-023 rst=1 on an edge SHALL clear all pipeline registers: d=0, bout=0, valid_out=0, ovf=0.
REQ-024 rst SHALL take priority over ce and valid_in on the same edge.
REQ-025 SHALL discard in-flight operations when reset is asserted mid-stream; no valid_out pulse for them after release.
REQ-026 SHALL sample valid_in normally on the first edge after rst deasserts.

Configuration
REQ-027 SUB_OVF_EN defined: SHALL add port ovf = (a[31]!=b[31]) && (d[31]!=a[31]), aligned with d (sign bits carried through the skew pipeline).
REQ-028 SUB_OVF_EN undefined: SHALL omit port ovf and its sign-tracking registers; all other behaviour identical.

Structure
REQ-029 SHALL place in package sub32_pkg: NUM_STAGES=8, NUM_CHUNKS=7, chunk width/offset constants, and a chunk-width-indexed typedef for chunk data.
REQ-030 SHALL use one sub-module, sub_chunk_reg (width parameter): registered chunk subtract with borrow, ce and sync reset; instantiated 7 times.

Verification
REQ-031 a=5, b=3, bin=0, valid_in=1 at edge 0 -> edge 8: d=2, bout=0, valid_out=1 for one cycle.
REQ-032 a=0, b=1, bin=0 -> d=32'hFFFFFFFF, bout=1; also a=b=32'h12345678, bin=1 -> d=32'hFFFFFFFF, bout=1.
REQ-033 Back-to-back stream of 100 random ops, with valid_in random -> outputs match reference model a-b-bin in order, 8-cycle latency, bubbles preserved.
REQ-034 ce=0 for 3 cycles mid-stream -> all outputs frozen; results resume in order, latency extended by exactly 3.
REQ-035 rst pulsed 4 cycles after 3 ops issued -> valid_out stays 0 for those ops; a new op issued after release completes 8 edges later.
REQ-036 SUB_OVF_EN: a=32'h80000000, b=1 -> d=32'h7FFFFFFF, ovf=1, bout=0; a=1, b=1 -> ovf=0.
